// File: rtl/i2s_rx_ctrl.sv
// I2S master receive controller: waits for a stable PLL lock, generates SCK/WS,
// deserialises left/right samples from SD and presents complete stereo frames.
module i2s_rx_ctrl #(
  parameter int CLK_DIV     = 4,
  parameter int SLOT_BITS   = 32,
  parameter int SAMPLE_BITS = 24,
  parameter int LOCK_HOLD   = 1024
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   pll_lock,
  input  logic                   enable,
  input  logic                   i2s_sd,
  output logic                   i2s_sck,
  output logic                   i2s_ws,
  output logic [SAMPLE_BITS-1:0] sample_l,
  output logic [SAMPLE_BITS-1:0] sample_r,
  output logic                   sample_valid,
  output logic                   running
);

  localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int B_W  = $clog2(2 * SLOT_BITS);
  localparam int SC_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;

  localparam logic [HC_W-1:0] HALF_LAST   = HC_W'(CLK_DIV - 1);
  localparam logic [B_W-1:0]  BIT_LAST    = B_W'(2 * SLOT_BITS - 1);
  localparam logic [B_W-1:0]  BIT_SLOT    = B_W'(SLOT_BITS);
  localparam logic [B_W-1:0]  LEFT_FIRST  = B_W'(1);
  localparam logic [B_W-1:0]  LEFT_LAST   = B_W'(SAMPLE_BITS);
  localparam logic [B_W-1:0]  RIGHT_FIRST = B_W'(SLOT_BITS + 1);
  localparam logic [B_W-1:0]  RIGHT_LAST  = B_W'(SLOT_BITS + SAMPLE_BITS);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'((LOCK_HOLD >= 2) ? LOCK_HOLD - 2 : 0);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, STOP} state_t;

  state_t                 state;
  logic                   lock_meta;
  logic                   lock_s;
  logic [HC_W-1:0]        half_cnt;
  logic [B_W-1:0]         bit_cnt;
  logic [SC_W-1:0]        settle_cnt;
  logic [SAMPLE_BITS-1:0] shift_l;
  logic [SAMPLE_BITS-1:0] shift_r;
  logic                   frame_done;

  // NOTE: non-blocking assignments make each stage of the chain take the
  // previous stage's old value, giving the two-flop delay on lock_s.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      i2s_sck      <= 1'b0;
      i2s_ws       <= 1'b0;
      half_cnt     <= '0;
      bit_cnt      <= '0;
      settle_cnt   <= '0;
      shift_l      <= '0;
      shift_r      <= '0;
      frame_done   <= 1'b0;
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
      running      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!lock_s) begin
        // Lock loss overrides everything, including a pending drain or strobe.
        state      <= IDLE;
        i2s_sck    <= 1'b0;
        i2s_ws     <= 1'b0;
        half_cnt   <= '0;
        bit_cnt    <= '0;
        settle_cnt <= '0;
        frame_done <= 1'b0;
        running    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            settle_cnt <= '0;
            if (enable) begin
              if (LOCK_HOLD == 1) begin
                state   <= RUN;
                running <= 1'b1;
              end else begin
                state <= SETTLE;
              end
            end
          end

          SETTLE: begin
            if (!enable) begin
              state      <= IDLE;
              settle_cnt <= '0;
            end else if (settle_cnt == SETTLE_LAST) begin
              state      <= RUN;
              running    <= 1'b1;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end

          RUN, STOP: begin
            if (state == RUN && !enable) state <= STOP;

            if (frame_done) begin
              sample_l     <= shift_l;
              sample_r     <= shift_r;
              sample_valid <= 1'b1;
              frame_done   <= 1'b0;
            end

            if (half_cnt == HALF_LAST) begin
              half_cnt <= '0;
              i2s_sck  <= ~i2s_sck;
              if (!i2s_sck) begin
                // Rising SCK: capture inside the one-bit-delayed sample windows.
                if (bit_cnt >= LEFT_FIRST && bit_cnt <= LEFT_LAST)
                  shift_l <= (shift_l << 1) | SAMPLE_BITS'(i2s_sd);
                if (bit_cnt >= RIGHT_FIRST && bit_cnt <= RIGHT_LAST)
                  shift_r <= (shift_r << 1) | SAMPLE_BITS'(i2s_sd);
                if (bit_cnt == RIGHT_LAST) frame_done <= 1'b1;
              end else if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                i2s_ws  <= 1'b0;
                if (state == STOP) begin
                  state   <= IDLE;
                  running <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                i2s_ws  <= ((bit_cnt + 1'b1) >= BIT_SLOT);
              end
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Directed bench for i2s_rx_ctrl: a codec model drives SD from its own cycle
// count and a scoreboard queue holds the stereo frames expected on sample_valid.
module tb_i2s_rx_ctrl;

  localparam int CLK_DIV     = 4;
  localparam int SLOT_BITS   = 32;
  localparam int SAMPLE_BITS = 24;
  localparam int LOCK_HOLD   = 16;
  localparam int BIT_CYC     = 2 * CLK_DIV;
  localparam int FRAME_CYC   = BIT_CYC * 2 * SLOT_BITS;

  logic                   clk_in;
  logic                   reset;
  logic                   pll_lock;
  logic                   enable;
  logic                   i2s_sd;
  logic                   i2s_sck;
  logic                   i2s_ws;
  logic [SAMPLE_BITS-1:0] sample_l;
  logic [SAMPLE_BITS-1:0] sample_r;
  logic                   sample_valid;
  logic                   running;

  i2s_rx_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .SLOT_BITS  (SLOT_BITS),
    .SAMPLE_BITS(SAMPLE_BITS),
    .LOCK_HOLD  (LOCK_HOLD)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .enable      (enable),
    .i2s_sd      (i2s_sd),
    .i2s_sck     (i2s_sck),
    .i2s_ws      (i2s_ws),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .sample_valid(sample_valid),
    .running     (running)
  );

  typedef struct {
    logic [SAMPLE_BITS-1:0] l;
    logic [SAMPLE_BITS-1:0] r;
    int                     off;
  } exp_t;

  exp_t                   sb[$];
  logic [SAMPLE_BITS-1:0] data_l[4];
  logic [SAMPLE_BITS-1:0] data_r[4];
  int                     cyc = 0;
  int                     n_total = 0;
  int                     n_pass = 0;
  int                     n_fail = 0;
  int                     run_t0 = 0;
  logic                   run_prev = 1'b0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk_in);
  endtask

  task automatic wait_run(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (running !== 1'b1 && n < budget);
  endtask

  function automatic logic sd_bit(input int b, input logic [SAMPLE_BITS-1:0] l,
                                  input logic [SAMPLE_BITS-1:0] r);
    if (b >= 1 && b <= SAMPLE_BITS) return l[SAMPLE_BITS - b];
    if (b >= SLOT_BITS + 1 && b <= SLOT_BITS + SAMPLE_BITS) return r[SLOT_BITS + SAMPLE_BITS - b];
    return 1'b1;
  endfunction

  // Codec model and scoreboard consumer, both timed from the first RUN cycle.
  always @(negedge clk_in) begin
    int   t0_now;
    int   k;
    exp_t e;
    t0_now = (running === 1'b1 && run_prev !== 1'b1) ? cyc : run_t0;
    if (running === 1'b1) begin
      k = cyc - t0_now;
      i2s_sd <= sd_bit((k / BIT_CYC) % (2 * SLOT_BITS), data_l[(k / FRAME_CYC) % 4],
                       data_r[(k / FRAME_CYC) % 4]);
    end else begin
      i2s_sd <= 1'b0;
    end
    if (sample_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 64'(sample_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("frame_left", 64'(sample_l), 64'(e.l));
        check("frame_right", 64'(sample_r), 64'(e.r));
        check("valid_cycle", 64'(cyc - t0_now), 64'(e.off));
      end
    end
    run_t0   <= t0_now;
    run_prev <= running;
  end

  initial begin
    int n;
    int t0;
    int t1;
    int t2;
    int t3;
    int x;
    int sck_hi;
    int run_hi;

    reset    = 1'b0;
    pll_lock = 1'b1;
    enable   = 1'b1;
    data_l[0] = 24'hA5A5A5;
    data_r[0] = 24'h5A5A5A;
    data_l[1] = 24'($urandom);
    data_r[1] = 24'($urandom);
    data_l[2] = 24'h000FFF;
    data_r[2] = 24'hFFF000;
    data_l[3] = 24'h0;
    data_r[3] = 24'h0;

    // Reset with lock and enable already high.
    repeat (3) @(negedge clk_in);
    check("rst_sck", 64'(i2s_sck), 64'd0);
    check("rst_ws", 64'(i2s_ws), 64'd0);
    check("rst_sample_l", 64'(sample_l), 64'd0);
    check("rst_sample_r", 64'(sample_r), 64'd0);
    check("rst_valid", 64'(sample_valid), 64'd0);
    check("rst_running", 64'(running), 64'd0);

    sb.push_back('{l: data_l[0], r: data_r[0], off: 453});
    sb.push_back('{l: data_l[1], r: data_r[1], off: 453 + FRAME_CYC});
    reset = 1'b1;
    wait_run(100, n);
    check("reset_to_running", 64'(n), 64'd18);
    t0 = cyc;

    // SCK/WS timing and held samples across two frames.
    check("t0_sck_low", 64'(i2s_sck), 64'd0);
    check("t0_ws_low", 64'(i2s_ws), 64'd0);
    wait_cyc(t0 + 3);
    check("sck_before_rise", 64'(i2s_sck), 64'd0);
    wait_cyc(t0 + 4);
    check("sck_first_rise", 64'(i2s_sck), 64'd1);
    wait_cyc(t0 + 8);
    check("sck_first_fall", 64'(i2s_sck), 64'd0);
    wait_cyc(t0 + 255);
    check("ws_left_end", 64'(i2s_ws), 64'd0);
    wait_cyc(t0 + 256);
    check("ws_right_start", 64'(i2s_ws), 64'd1);
    wait_cyc(t0 + 500);
    check("hold_l", 64'(sample_l), 64'h00A5A5A5);
    check("hold_r", 64'(sample_r), 64'h005A5A5A);
    wait_cyc(t0 + 512);
    check("ws_wrap", 64'(i2s_ws), 64'd0);
    wait_cyc(t0 + 1100);
    check("two_frames_seen", 64'(sb.size()), 64'd0);

    // Lock loss at b=40 of the third frame.
    wait_cyc(t0 + 1346);
    pll_lock = 1'b0;
    wait_cyc(t0 + 1349);
    check("lockloss_sck", 64'(i2s_sck), 64'd0);
    check("lockloss_ws", 64'(i2s_ws), 64'd0);
    check("lockloss_running", 64'(running), 64'd0);
    wait_cyc(t0 + 1400);
    check("lockloss_keeps_l", 64'(sample_l), 64'(data_l[1]));

    // Relock: full settle, bit counter restarts; enable drops at b=10.
    data_l[0] = 24'h123456;
    data_r[0] = 24'hFEDCBA;
    sb.push_back('{l: data_l[0], r: data_r[0], off: 453});
    pll_lock = 1'b1;
    wait_run(100, n);
    check("relock_to_running", 64'(n), 64'd18);
    t1 = cyc;
    wait_cyc(t1 + 80);
    enable = 1'b0;
    wait_cyc(t1 + 255);
    check("relock_ws_left", 64'(i2s_ws), 64'd0);
    wait_cyc(t1 + 256);
    check("relock_ws_right", 64'(i2s_ws), 64'd1);
    wait_cyc(t1 + 300);
    enable = 1'b1;
    wait_cyc(t1 + 511);
    check("stop_running_last", 64'(running), 64'd1);
    check("stop_sck_last", 64'(i2s_sck), 64'd1);
    wait_cyc(t1 + 512);
    check("stop_running_end", 64'(running), 64'd0);
    check("stop_sck_end", 64'(i2s_sck), 64'd0);
    check("stop_ws_end", 64'(i2s_ws), 64'd0);
    wait_cyc(t1 + 520);
    data_l[0] = 24'($urandom);
    data_r[0] = 24'($urandom);
    sb.push_back('{l: data_l[0], r: data_r[0], off: 453});
    wait_cyc(t1 + 527);
    check("reenable_settling", 64'(running), 64'd0);
    wait_cyc(t1 + 528);
    check("reenable_running", 64'(running), 64'd1);
    t2 = cyc;

    // Stop right at RUN entry: one full frame drains.
    enable = 1'b0;
    wait_cyc(t2 + 511);
    check("drain_running", 64'(running), 64'd1);
    wait_cyc(t2 + 512);
    check("drain_done", 64'(running), 64'd0);

    // Enable dropped during SETTLE: SCK never toggles.
    wait_cyc(t2 + 520);
    enable = 1'b1;
    wait_cyc(t2 + 526);
    enable = 1'b0;
    sck_hi = 0;
    run_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (i2s_sck !== 1'b0) sck_hi++;
      if (running !== 1'b0) run_hi++;
    end
    check("settle_abort_sck", 64'(sck_hi), 64'd0);
    check("settle_abort_running", 64'(run_hi), 64'd0);

    // One-cycle lock_s glitch at settle count 10.
    data_l[0] = 24'($urandom);
    data_r[0] = 24'($urandom);
    sb.push_back('{l: data_l[0], r: data_r[0], off: 453});
    x = cyc;
    enable = 1'b1;
    wait_cyc(x + 9);
    pll_lock = 1'b0;
    wait_cyc(x + 10);
    pll_lock = 1'b1;
    wait_run(100, n);
    check("glitch_to_running", 64'(n), 64'd18);
    t3 = cyc;

    // Enable and lock drop together mid right slot: no drain, no strobe.
    wait_cyc(t3 + 834);
    enable   = 1'b0;
    pll_lock = 1'b0;
    wait_cyc(t3 + 837);
    check("both_drop_sck", 64'(i2s_sck), 64'd0);
    check("both_drop_ws", 64'(i2s_ws), 64'd0);
    check("both_drop_running", 64'(running), 64'd0);
    wait_cyc(t3 + 900);
    check("both_drop_no_drain", 64'(running), 64'd0);
    wait_cyc(t3 + 1100);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
